// File: rtl/prog_loader.sv
`default_nettype none
// =============================================================================
// Module   : prog_loader
// Purpose  : Streams a boot image into imem, optionally XOR-checks it, then
//            releases the core from reset.
// Revision : 1.0 - initial release
// =============================================================================
module prog_loader #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter bit                CHECKSUM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] csum;
    logic              xfer;
    logic              len_ok;
    logic              last;

    assign s_ready   = ((state == LOAD) || (state == CHECK)) && !abort;
    assign xfer      = s_valid && s_ready;
    assign len_ok    = (len != '0) && (len <= MAX_LEN);
    assign last      = (count == (len_q - ONE));
    assign busy      = (state == LOAD) || (state == CHECK);
    assign done      = (state == RUN);
    assign cpu_rst_n = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            len_q     <= '0;
            csum      <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        if (len_ok) begin
                            state <= LOAD;
                            len_q <= len;
                            count <= '0;
                            csum  <= '0;
                            err   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (xfer) begin
                        // Address wraps naturally at the ADDR_W boundary.
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_ADDR + count[ADDR_W-1:0];
                        mem_wdata <= s_data;
                        csum      <= csum ^ s_data;
                        count     <= count + ONE;
                        if (last) begin
                            state <= CHECKSUM_EN ? CHECK : RUN;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (xfer) begin
                        if (s_data == csum) begin
                            state <= RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// =============================================================================
// Module   : tb_prog_loader
// Purpose  : Randomized self-checking bench for prog_loader (two configurations).
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int CAP = 64;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_CHECK = 2;
    localparam int P_RUN   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start     [2];
    logic          abort     [2];
    logic          s_valid   [2];
    logic [AW:0]   len       [2];
    logic [DW-1:0] s_data    [2];
    logic          s_ready   [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic          cpu_rst_n [2];
    logic          busy      [2];
    logic          done      [2];
    logic          err       [2];

    prog_loader #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(6'd0), .CHECKSUM_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .len(len[0]),
        .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .cpu_rst_n(cpu_rst_n[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    prog_loader #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(6'd62), .CHECKSUM_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .len(len[1]),
        .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .cpu_rst_n(cpu_rst_n[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // Reference model: loader phase and progress per instance.
    int          ph    [2];
    int          cnt   [2];
    int          mlen  [2];
    logic [31:0] mcs   [2];
    bit          merr  [2];
    int          base  [2] = '{0, 62};
    bit          cen   [2] = '{1'b1, 1'b0};
    int          wr_cnt[2];
    int          addr_log[$];
    int          checks;
    int          failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input int d);
        check({tag, "_s_ready"},   32'(s_ready[d]),   32'd0);
        check({tag, "_mem_we"},    32'(mem_we[d]),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr[d]),  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata[d],      32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n[d]), 32'd0);
        check({tag, "_busy"},      32'(busy[d]),      32'd0);
        check({tag, "_done"},      32'(done[d]),      32'd0);
        check({tag, "_err"},       32'(err[d]),       32'd0);
    endtask

    // Advance one clock: predict each instance from the current inputs,
    // then compare against the outputs seen on the following falling edge.
    task automatic step();
        bit          we_e [2];
        int          a_e  [2];
        logic [31:0] d_e  [2];
        bit          acc;
        #1;
        for (int d = 0; d < 2; d++) begin
            acc = ((ph[d] == P_LOAD) || (ph[d] == P_CHECK)) && !abort[d];
            check($sformatf("d%0d_s_ready", d), 32'(s_ready[d]), 32'(acc));
            we_e[d] = 1'b0;
            a_e[d]  = 0;
            d_e[d]  = '0;
            if (!rst_n) begin
                ph[d] = P_IDLE; merr[d] = 1'b0; cnt[d] = 0; mcs[d] = '0;
            end else if (((ph[d] == P_IDLE) || (ph[d] == P_RUN)) && start[d]) begin
                if ((int'(len[d]) >= 1) && (int'(len[d]) <= CAP)) begin
                    ph[d] = P_LOAD; mlen[d] = int'(len[d]); cnt[d] = 0; mcs[d] = '0; merr[d] = 1'b0;
                end else begin
                    ph[d] = P_IDLE; merr[d] = 1'b1;
                end
            end else if (((ph[d] == P_LOAD) || (ph[d] == P_CHECK)) && abort[d]) begin
                ph[d] = P_IDLE; merr[d] = 1'b1;
            end else if ((ph[d] == P_LOAD) && s_valid[d]) begin
                we_e[d] = 1'b1;
                a_e[d]  = (base[d] + cnt[d]) % CAP;
                d_e[d]  = s_data[d];
                mcs[d]  = mcs[d] ^ s_data[d];
                cnt[d]++;
                if (cnt[d] == mlen[d]) ph[d] = cen[d] ? P_CHECK : P_RUN;
            end else if ((ph[d] == P_CHECK) && s_valid[d]) begin
                if (s_data[d] == mcs[d]) ph[d] = P_RUN;
                else begin ph[d] = P_IDLE; merr[d] = 1'b1; end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_mem_we", d), 32'(mem_we[d]), 32'(we_e[d]));
            if (we_e[d]) begin
                check($sformatf("d%0d_mem_addr", d), 32'(mem_addr[d]), 32'(a_e[d]));
                check($sformatf("d%0d_mem_wdata", d), mem_wdata[d], d_e[d]);
            end
            if (mem_we[d]) begin
                wr_cnt[d]++;
                if (d == 1) addr_log.push_back(int'(mem_addr[1]));
            end
            check($sformatf("d%0d_busy", d), 32'(busy[d]), 32'((ph[d] == P_LOAD) || (ph[d] == P_CHECK)));
            check($sformatf("d%0d_done", d), 32'(done[d]), 32'(ph[d] == P_RUN));
            check($sformatf("d%0d_cpu_rst_n", d), 32'(cpu_rst_n[d]), 32'(ph[d] == P_RUN));
            check($sformatf("d%0d_err", d), 32'(err[d]), 32'(merr[d]));
        end
    endtask

    task automatic start_load(input int d, input int n);
        start[d] = 1'b1;
        len[d]   = 7'(n);
        step();
        start[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [31:0] w, input int max_stall);
        int n;
        n = $urandom_range(max_stall, 0);
        for (int i = 0; i < n; i++) begin
            s_valid[d] = 1'b0;
            s_data[d]  = $urandom;
            step();
        end
        s_valid[d] = 1'b1;
        s_data[d]  = w;
        step();
        s_valid[d] = 1'b0;
    endtask

    task automatic load_image(input int d, input int n, input int max_stall,
                              input bit bad, input int abort_at);
        logic [31:0] x;
        logic [31:0] w;
        x = '0;
        start_load(d, n);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                abort[d]   = 1'b1;
                s_valid[d] = 1'b1;
                s_data[d]  = $urandom;
                step();
                abort[d]   = 1'b0;
                s_valid[d] = 1'b0;
                step();
                return;
            end
            w = $urandom;
            x = x ^ w;
            send(d, w, max_stall);
        end
        if (cen[d]) send(d, bad ? ~x : x, max_stall);
        step();
    endtask

    initial begin
        logic [31:0] img [3];
        logic [31:0] x;
        bit          pat [5];
        int          n, d, ab;
        bit          bad;

        checks = 0; failures = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; s_valid[i] = 1'b0;
            len[i] = '0; s_data[i] = '0;
            ph[i] = P_IDLE; cnt[i] = 0; mlen[i] = 0; mcs[i] = '0; merr[i] = 1'b0; wr_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        step();
        check_all_zero("reset_d0", 0);
        check_all_zero("reset_d1", 1);
        rst_n = 1'b1;
        step();

        // Fixed image, good checksum (XOR of the three words = 201100EA).
        img = '{32'h201000E8, 32'h20080005, 32'h20090007};
        wr_cnt[0] = 0;
        start_load(0, 3);
        for (int i = 0; i < 3; i++) send(0, img[i], 0);
        send(0, 32'h201100EA, 0);
        step();
        check("t1_done", 32'(done[0]), 32'd1);
        check("t1_cpu_rst_n", 32'(cpu_rst_n[0]), 32'd1);
        check("t1_err", 32'(err[0]), 32'd0);
        check("t1_writes", 32'(wr_cnt[0]), 32'd3);

        // Same image reloaded from RUN with a wrong checksum.
        wr_cnt[0] = 0;
        start_load(0, 3);
        check("t2_cpu_rst_n_drop", 32'(cpu_rst_n[0]), 32'd0);
        for (int i = 0; i < 3; i++) send(0, img[i], 1);
        send(0, 32'h0000_0000, 0);
        step();
        check("t2_err", 32'(err[0]), 32'd1);
        check("t2_cpu_rst_n", 32'(cpu_rst_n[0]), 32'd0);
        check("t2_busy", 32'(busy[0]), 32'd0);
        check("t2_writes", 32'(wr_cnt[0]), 32'd3);

        // Wrapping address from base 62, no checksum word.
        wr_cnt[1] = 0;
        addr_log.delete();
        start_load(1, 4);
        for (int i = 0; i < 4; i++) send(1, $urandom, 2);
        check("t3_done_with_last", 32'(done[1] & mem_we[1]), 32'd1);
        check("t3_nwrites", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            check("t3_addr0", 32'(addr_log[0]), 32'd62);
            check("t3_addr1", 32'(addr_log[1]), 32'd63);
            check("t3_addr2", 32'(addr_log[2]), 32'd0);
            check("t3_addr3", 32'(addr_log[3]), 32'd1);
        end

        // Valid pattern 1,0,0,1,1.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        wr_cnt[0] = 0;
        x = '0;
        start_load(0, 3);
        for (int i = 0; i < 5; i++) begin
            s_valid[0] = pat[i];
            s_data[0]  = $urandom;
            if (pat[i]) x = x ^ s_data[0];
            step();
        end
        s_valid[0] = 1'b0;
        check("t4_writes", 32'(wr_cnt[0]), 32'd3);
        send(0, x, 0);
        step();
        check("t4_done", 32'(done[0]), 32'd1);

        // Abort after two of five words, then a clean reload.
        wr_cnt[0] = 0;
        load_image(0, 5, 1, 1'b0, 2);
        check("t5_err", 32'(err[0]), 32'd1);
        check("t5_busy", 32'(busy[0]), 32'd0);
        check("t5_writes", 32'(wr_cnt[0]), 32'd2);
        wr_cnt[0] = 0;
        start_load(0, 5);
        check("t5_err_cleared", 32'(err[0]), 32'd0);
        x = '0;
        for (int i = 0; i < 5; i++) begin
            s_data[0] = $urandom;
            x = x ^ s_data[0];
            send(0, s_data[0], 3);
        end
        send(0, x, 0);
        step();
        check("t5_reload_done", 32'(done[0]), 32'd1);
        check("t5_reload_writes", 32'(wr_cnt[0]), 32'd5);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("t5_abort_ignored_run", 32'(done[0]), 32'd1);

        // Reset mid-load, then illegal and boundary lengths.
        start_load(0, 4);
        send(0, $urandom, 0);
        send(0, $urandom, 0);
        rst_n = 1'b0;
        step();
        check_all_zero("t6_reset", 0);
        rst_n = 1'b1;
        step();
        start_load(0, 0);
        check("t6_len0_err", 32'(err[0]), 32'd1);
        check("t6_len0_busy", 32'(busy[0]), 32'd0);
        start_load(0, 65);
        check("t6_len65_err", 32'(err[0]), 32'd1);
        wr_cnt[1] = 0;
        load_image(1, 64, 0, 1'b0, -1);
        check("t6_full_writes", 32'(wr_cnt[1]), 32'd64);
        check("t6_full_done", 32'(done[1]), 32'd1);

        // Randomized loads on both instances.
        for (int it = 0; it < 16; it++) begin
            d   = int'($urandom_range(1, 0));
            n   = int'($urandom_range(CAP, 1));
            bad = ($urandom_range(3, 0) == 0);
            ab  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            wr_cnt[d] = 0;
            load_image(d, n, 2, bad, ab);
            check($sformatf("rand%0d_writes", it), 32'(wr_cnt[d]), 32'((ab >= 0) ? ab : n));
            check($sformatf("rand%0d_done", it), 32'(done[d]),
                  32'((ab < 0) && (!bad || !cen[d])));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
